// File: rtl/stall_bus_pkg.sv
// Shared types and constants for the dual-lane stall bus endpoint.
package stall_bus_pkg;

  localparam int BUS_DATA_W = 8;

  typedef struct packed {
    logic [BUS_DATA_W-1:0] data;
    logic                  enable;
  } bus_t;

endpackage

// File: rtl/stall_bus_unit_enable_reg.sv
// Registered non-zero flag for one lane; NEG_EDGE selects the clock edge it lives on.
import stall_bus_pkg::*;

module bus_enable_reg #(
  parameter int DATA_W   = BUS_DATA_W,
  parameter bit NEG_EDGE = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_i,
  input  logic              stall_i,
  output logic              enable_o
);

  logic enable_q;
  logic enable_d;

  always_comb begin
    enable_d = enable_q;
    if (!stall_i) enable_d = |data_i;
  end

  // Only one of the two register flavours exists after elaboration.
  generate
    if (NEG_EDGE) begin : g_neg
      always_ff @(negedge clk) begin
        if (!rst_n) enable_q <= 1'b0;
        else        enable_q <= enable_d;
      end
    end else begin : g_pos
      always_ff @(posedge clk) begin
        if (!rst_n) enable_q <= 1'b0;
        else        enable_q <= enable_d;
      end
    end
  endgenerate

  assign enable_o = enable_q;

endmodule

// File: rtl/stall_bus_unit.sv
// Dual-lane endpoint: lane A flag on the rising edge, lane B flag and the
// lane A capture register on the falling edge of the same clock.
import stall_bus_pkg::*;

module stall_bus_unit #(
  parameter int DATA_W = BUS_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] a_data,
  input  logic [DATA_W-1:0] b_data,
  input  logic              stall,
  output logic              a_enable,
  output logic              b_enable,
  output logic [DATA_W-1:0] cap_data,
  output logic              cap_valid
);

  logic [DATA_W-1:0] cap_data_q;
  logic [DATA_W-1:0] cap_data_d;
  logic              cap_valid_q;
  logic              cap_valid_d;

  bus_enable_reg #(.DATA_W(DATA_W), .NEG_EDGE(1'b0)) u_lane_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .data_i   (a_data),
    .stall_i  (stall),
    .enable_o (a_enable)
  );

  bus_enable_reg #(.DATA_W(DATA_W), .NEG_EDGE(1'b1)) u_lane_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .data_i   (b_data),
    .stall_i  (stall),
    .enable_o (b_enable)
  );

  // a_enable here is the value registered at the preceding rising edge.
  always_comb begin
    cap_data_d  = cap_data_q;
    cap_valid_d = cap_valid_q;
    if (a_enable && !stall) begin
      cap_data_d  = a_data;
      cap_valid_d = 1'b1;
    end
  end

  always_ff @(negedge clk) begin
    if (!rst_n) begin
      cap_data_q  <= '0;
      cap_valid_q <= 1'b0;
    end else begin
      cap_data_q  <= cap_data_d;
      cap_valid_q <= cap_valid_d;
    end
  end

  assign cap_data  = cap_data_q;
  assign cap_valid = cap_valid_q;

endmodule

// File: tb/tb_stall_bus_unit.sv
// Directed bench for stall_bus_unit: lanes, capture, stall, zero-data edge, reset.
module tb_stall_bus_unit;

  logic       clk;
  logic       rst_n;
  logic [7:0] a_data;
  logic [7:0] b_data;
  logic       stall;
  logic       a_enable;
  logic       b_enable;
  logic [7:0] cap_data;
  logic       cap_valid;

  int checks;
  int failures;

  stall_bus_unit #(.DATA_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a_data    (a_data),
    .b_data    (b_data),
    .stall     (stall),
    .a_enable  (a_enable),
    .b_enable  (b_enable),
    .cap_data  (cap_data),
    .cap_valid (cap_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic test_reset();
    rst_n = 1'b0; a_data = 8'hFF; b_data = 8'hFF; stall = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    checks++; if (a_enable !== 1'b0) begin failures++; $display("FAIL reset_a_enable got=%b exp=0", a_enable); end
    checks++; if (b_enable !== 1'b0) begin failures++; $display("FAIL reset_b_enable got=%b exp=0", b_enable); end
    checks++; if (cap_data !== 8'h00) begin failures++; $display("FAIL reset_cap_data got=%h exp=00", cap_data); end
    checks++; if (cap_valid !== 1'b0) begin failures++; $display("FAIL reset_cap_valid got=%b exp=0", cap_valid); end
    rst_n = 1'b1; a_data = 8'h00; b_data = 8'h00;
  endtask

  task automatic test_lane_a();
    @(posedge clk); #1;
    checks++; if (a_enable !== 1'b0) begin failures++; $display("FAIL lane_a_zero got=%b exp=0", a_enable); end
    a_data = 8'h04;
    @(negedge clk); #1;
    checks++; if (cap_valid !== 1'b0) begin failures++; $display("FAIL lane_a_no_early_cap got=%b exp=0", cap_valid); end
    @(posedge clk); #1;
    checks++; if (a_enable !== 1'b1) begin failures++; $display("FAIL lane_a_enable got=%b exp=1", a_enable); end
    checks++; if (cap_valid !== 1'b0) begin failures++; $display("FAIL lane_a_cap_wait got=%b exp=0", cap_valid); end
    @(negedge clk); #1;
    checks++; if (cap_data !== 8'h04) begin failures++; $display("FAIL lane_a_cap_data got=%h exp=04", cap_data); end
    checks++; if (cap_valid !== 1'b1) begin failures++; $display("FAIL lane_a_cap_valid got=%b exp=1", cap_valid); end
  endtask

  task automatic test_lane_b();
    b_data = 8'h10;
    @(posedge clk); #1;
    checks++; if (b_enable !== 1'b0) begin failures++; $display("FAIL lane_b_not_on_rise got=%b exp=0", b_enable); end
    @(negedge clk); #1;
    checks++; if (b_enable !== 1'b1) begin failures++; $display("FAIL lane_b_enable got=%b exp=1", b_enable); end
    b_data = 8'h00;
    @(negedge clk); #1;
    checks++; if (b_enable !== 1'b0) begin failures++; $display("FAIL lane_b_clear got=%b exp=0", b_enable); end
    checks++; if (a_enable !== 1'b1) begin failures++; $display("FAIL lane_b_a_unaffected got=%b exp=1", a_enable); end
    checks++; if (cap_data !== 8'h04) begin failures++; $display("FAIL lane_b_cap_hold got=%h exp=04", cap_data); end
  endtask

  task automatic test_stall();
    stall = 1'b1; a_data = 8'h00; b_data = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++; if (a_enable !== 1'b1) begin failures++; $display("FAIL stall_a_hold[%0d] got=%b exp=1", i, a_enable); end
      a_data = 8'h55;
      @(negedge clk); #1;
      checks++; if (cap_data !== 8'h04) begin failures++; $display("FAIL stall_cap_hold[%0d] got=%h exp=04", i, cap_data); end
      checks++; if (b_enable !== 1'b0) begin failures++; $display("FAIL stall_b_hold[%0d] got=%b exp=0", i, b_enable); end
      checks++; if (cap_valid !== 1'b1) begin failures++; $display("FAIL stall_valid_hold[%0d] got=%b exp=1", i, cap_valid); end
    end
    stall = 1'b0;
    @(posedge clk); #1;
    checks++; if (a_enable !== 1'b1) begin failures++; $display("FAIL unstall_a got=%b exp=1", a_enable); end
    @(negedge clk); #1;
    checks++; if (cap_data !== 8'h55) begin failures++; $display("FAIL unstall_cap got=%h exp=55", cap_data); end
    checks++; if (b_enable !== 1'b1) begin failures++; $display("FAIL unstall_b got=%b exp=1", b_enable); end
  endtask

  task automatic test_zero_data();
    @(posedge clk); #1;
    checks++; if (a_enable !== 1'b1) begin failures++; $display("FAIL zero_pre_a got=%b exp=1", a_enable); end
    a_data = 8'h00;
    @(negedge clk); #1;
    checks++; if (cap_data !== 8'h00) begin failures++; $display("FAIL zero_cap got=%h exp=00", cap_data); end
    checks++; if (cap_valid !== 1'b1) begin failures++; $display("FAIL zero_valid got=%b exp=1", cap_valid); end
    @(posedge clk); #1;
    checks++; if (a_enable !== 1'b0) begin failures++; $display("FAIL zero_a_drop got=%b exp=0", a_enable); end
    @(negedge clk); #1;
    checks++; if (cap_valid !== 1'b1) begin failures++; $display("FAIL zero_valid_stays got=%b exp=1", cap_valid); end
  endtask

  task automatic test_mid_reset();
    a_data = 8'h33;
    @(posedge clk); #1;
    checks++; if (a_enable !== 1'b1) begin failures++; $display("FAIL mid_pre_a got=%b exp=1", a_enable); end
    @(negedge clk); #1;
    checks++; if (cap_data !== 8'h33) begin failures++; $display("FAIL mid_pre_cap got=%h exp=33", cap_data); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++; if (a_enable !== 1'b0) begin failures++; $display("FAIL mid_rst_a got=%b exp=0", a_enable); end
    @(negedge clk); #1;
    checks++; if (cap_data !== 8'h00) begin failures++; $display("FAIL mid_rst_cap got=%h exp=00", cap_data); end
    checks++; if (cap_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_valid got=%b exp=0", cap_valid); end
    checks++; if (b_enable !== 1'b0) begin failures++; $display("FAIL mid_rst_b got=%b exp=0", b_enable); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (a_enable !== 1'b1) begin failures++; $display("FAIL post_rst_a got=%b exp=1", a_enable); end
    checks++; if (cap_valid !== 1'b0) begin failures++; $display("FAIL post_rst_valid_wait got=%b exp=0", cap_valid); end
    @(negedge clk); #1;
    checks++; if (cap_data !== 8'h33) begin failures++; $display("FAIL post_rst_cap got=%h exp=33", cap_data); end
    checks++; if (cap_valid !== 1'b1) begin failures++; $display("FAIL post_rst_valid got=%b exp=1", cap_valid); end
    checks++; if (b_enable !== 1'b1) begin failures++; $display("FAIL post_rst_b got=%b exp=1", b_enable); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_lane_a();
    test_lane_b();
    test_stall();
    test_zero_data();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
